param_sh_unit: RTL and testbench
================================

// Module: param_sh_unit
// PURPOSE
//   Parametrised multi-mode shift register: parallel load, plus multi-cycle shifts.
//   One shift is performed per clock, by a programmable amount, in a mode latched at start.
//   Successor to the fixed 16-bit load/shift register used in the datapath labs.
//   Feeds serial-arithmetic units (shift-add multiplier, normaliser) that need busy/done handshake.
// PARAMETERS
//   WIDTH  16                    data width in bits (>=2)
//   CW     $clog2(WIDTH)+1       localparam, width of amt and internal counter
// PORTS
//   clk     in   1      clock, all state updates on rising edge
//   rst_b   in   1      reset, synchronous, active-low
//   d       in   WIDTH  parallel load data
//   ld      in   1      parallel load request (IDLE only)
//   start   in   1      start multi-cycle shift (IDLE only)
//   mode    in   3      000 SHL, 001 SHR, 010 SAR, 011 ROL, 100 ROR, others NOP
//   amt     in   CW     shift amount 0..WIDTH; values >WIDTH saturate to WIDTH
//   sh_in   in   1      serial fill bit for SHL/SHR, sampled live on every shift edge
//   q       out  WIDTH  register contents
//   sh_out  out  1      registered bit shifted/rotated out on most recent shift
//   busy    out  1      1 while state==SHIFT
//   done    out  1      one-cycle pulse, 1 while state==DONE
// BEHAVIOUR
//   Reset: rst_b==0 at an edge -> q=0, sh_out=0, busy=0, done=0, cnt=0, state=IDLE.
//     Reset has priority over everything. Mid-shift reset aborts with no done pulse.
//   FSM: IDLE, SHIFT, DONE. All outputs are registered or decoded from state.
//   IDLE:
//     ld=1 -> q<=d, stay IDLE. ld has priority over start when both are high.
//     start=1, ld=0 -> latch mode. Let n = min(amt, WIDTH).
//       n==0 -> state<=DONE, q and sh_out unchanged.
//       n==1 -> perform one shift this edge, state<=DONE.
//       n>1  -> perform one shift this edge, cnt<=n-1, state<=SHIFT.
//     Otherwise hold.
//   SHIFT:
//     Each edge performs one shift using the latched mode; cnt<=cnt-1.
//     cnt==1 at the edge -> last shift, state<=DONE.
//     ld/start/mode/amt are ignored (no queuing). sh_in is still sampled each edge.
//   DONE: done=1 for exactly one cycle; next edge state<=IDLE.
//     ld/start are ignored in DONE.
//   Latency: start at edge E0 with n>=1 -> shifts at E0..E(n-1).
//     Final q is visible after E(n-1); done=1 in the cycle after E(n-1).
//     busy=1 for n-1 cycles.
//   Per-shift ops (W=WIDTH):
//     SHL: q<={q[W-2:0],sh_in},        sh_out<=q[W-1]
//     SHR: q<={sh_in,q[W-1:1]},        sh_out<=q[0]
//     SAR: q<={q[W-1],q[W-1:1]},       sh_out<=q[0]; sh_in ignored
//     ROL: q<={q[W-2:0],q[W-1]},       sh_out<=q[W-1]
//     ROR: q<={q[0],q[W-1:1]},         sh_out<=q[0]
//     NOP: q, sh_out hold; counting and handshake proceed normally.
//   Saturation: amt>WIDTH is treated as WIDTH. A ROL/ROR by WIDTH returns the original q.
// TESTING (WIDTH=16)
//   1. q preloaded, rst_b=0 one edge -> q=16'h0000, busy=0, done=0, sh_out=0; no change while rst_b=0.
//   2. ld=1, d=16'hAB00 -> q=16'hAB00 next edge. ld=1 with start=1 -> load only, busy stays 0.
//   3. q=16'hAB00, start, SHL, amt=4, sh_in=1 -> after 4 edges q=16'hB00F, sh_out=0, busy=1 for 3 cycles, then done pulse.
//   4. q=16'h8000, SAR, amt=3 -> q=16'hF000, sh_out=0.
//      q=16'h1234, ROR, amt=4 -> q=16'h4123, sh_out=0.
//   5. amt=0 -> done the next cycle, q unchanged.
//      q=16'h1234, ROL, amt=20 -> saturates to 16: q=16'h1234, busy for 15 cycles.
//   6. start during SHIFT -> ignored.
//      rst_b=0 mid-SHIFT -> q=0 and state=IDLE next edge, no done pulse; a fresh start afterwards works.

Source files
------------

// File: rtl/param_sh_if.sv
// Control/data bundle for param_sh_unit: load/start requests, shift setup, and the
// register contents with the busy/done handshake.
interface param_sh_if #(
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] d;
  logic             ld;
  logic             start;
  logic [2:0]       mode;
  logic [CW-1:0]    amt;
  logic             sh_in;
  logic [WIDTH-1:0] q;
  logic             sh_out;
  logic             busy;
  logic             done;

  modport master (
    output d, ld, start, mode, amt, sh_in,
    input  q, sh_out, busy, done
  );

  modport slave (
    input  d, ld, start, mode, amt, sh_in,
    output q, sh_out, busy, done
  );
endinterface

// File: rtl/param_sh_unit.sv
// Parametrised load/shift register: parallel load in IDLE, then one shift per clock
// by a saturated amount in a mode captured at start, ending with a one-cycle done.
module param_sh_unit #(
  parameter int WIDTH = 16
) (
  input logic        clk,
  input logic        rst_b,
  param_sh_if.slave  sh
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sh_out_q, sh_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [CW-1:0]    n_amt;
  logic [WIDTH:0]   shift_res;
  logic [2:0]       shift_mode;

  // Amounts beyond the register width behave as a full-width shift.
  function automatic logic [CW-1:0] sat_amt(input logic [CW-1:0] a);
    if (a > CW'(WIDTH)) return CW'(WIDTH);
    return a;
  endfunction

  // Returns {bit shifted out, new register value}; unknown modes hold both.
  function automatic logic [WIDTH:0] shift_op(input logic [2:0]       m,
                                              input logic [WIDTH-1:0] v,
                                              input logic             fill,
                                              input logic             so_prev);
    case (m)
      3'b000:  return {v[WIDTH-1], v[WIDTH-2:0], fill};
      3'b001:  return {v[0], fill, v[WIDTH-1:1]};
      3'b010:  return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      3'b011:  return {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      3'b100:  return {v[0], v[0], v[WIDTH-1:1]};
      default: return {so_prev, v};
    endcase
  endfunction

  always_comb begin
    n_amt      = sat_amt(sh.amt);
    shift_mode = (state_q == S_IDLE) ? sh.mode : mode_q;
    shift_res  = shift_op(shift_mode, data_q, sh.sh_in, sh_out_q);
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sh_out_d = sh_out_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    case (state_q)
      S_IDLE: begin
        if (sh.ld) begin
          data_d = sh.d;
        end else if (sh.start) begin
          mode_d = sh.mode;
          if (n_amt == '0) begin
            state_d = S_DONE;
          end else begin
            {sh_out_d, data_d} = shift_res;
            if (n_amt == CW'(1)) begin
              state_d = S_DONE;
            end else begin
              cnt_d   = n_amt - CW'(1);
              state_d = S_SHIFT;
            end
          end
        end
      end
      S_SHIFT: begin
        {sh_out_d, data_d} = shift_res;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset clears contents too so a mid-shift abort leaves q at zero.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      sh_out_q <= 1'b0;
      cnt_q    <= '0;
      mode_q   <= 3'b000;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      sh_out_q <= sh_out_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
    end
  end

  assign sh.q      = data_q;
  assign sh.sh_out = sh_out_q;
  assign sh.busy   = (state_q == S_SHIFT);
  assign sh.done   = (state_q == S_DONE);
endmodule

// File: tb/tb_param_sh_unit.sv
// Directed bench for param_sh_unit (WIDTH=16): load, each shift mode, saturation,
// zero/one-step shifts, ignored start while busy and mid-shift reset.
module tb_param_sh_unit;
  localparam int WIDTH = 16;

  logic clk;
  logic rst_b;
  int   n_tests;
  int   n_fail;
  int   bc;

  param_sh_if #(.WIDTH(WIDTH)) bus ();

  param_sh_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .sh    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.ld = 1'b1;
    bus.d  = v;
    step();
    bus.ld = 1'b0;
  endtask

  // Issues start, then counts busy cycles until done (bounded); leaves the bench in the DONE cycle.
  task automatic run_shift(input logic [2:0] m, input logic [4:0] a, input logic fill,
                           output int busy_cycles);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.amt   = a;
    bus.sh_in = fill;
    step();
    bus.start = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40 && bus.busy; i++) begin
      busy_cycles++;
      step();
    end
    if (bus.busy) chk("timeout", 32'd1, 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_b     = 1'b0;
    bus.d     = '0;
    bus.ld    = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 3'b000;
    bus.amt   = '0;
    bus.sh_in = 1'b0;
    step();
    step();
    rst_b = 1'b1;

    // Reset clears a preloaded value and holds while asserted
    do_load(16'hAAAA);
    chk("preload", bus.q, 16'hAAAA);
    rst_b = 1'b0;
    step();
    chk("rst_q", bus.q, 16'h0000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_sh_out", bus.sh_out, 1'b0);
    bus.ld = 1'b1; bus.d = 16'hFFFF; bus.start = 1'b1; bus.amt = 5'd3;
    step();
    chk("rst_hold_q", bus.q, 16'h0000);
    chk("rst_hold_busy", bus.busy, 1'b0);
    bus.ld = 1'b0; bus.start = 1'b0;
    rst_b = 1'b1;

    // Load wins over start
    bus.ld = 1'b1; bus.d = 16'hAB00; bus.start = 1'b1; bus.mode = 3'b000; bus.amt = 5'd4;
    step();
    bus.ld = 1'b0; bus.start = 1'b0;
    chk("ld_q", bus.q, 16'hAB00);
    chk("ld_busy", bus.busy, 1'b0);
    chk("ld_done", bus.done, 1'b0);
    step();
    chk("ld_idle_busy", bus.busy, 1'b0);
    chk("ld_idle_q", bus.q, 16'hAB00);

    // SHL by 4 with sh_in=1
    run_shift(3'b000, 5'd4, 1'b1, bc);
    chk("shl_busy_cycles", bc, 3);
    chk("shl_done", bus.done, 1'b1);
    chk("shl_q", bus.q, 16'hB00F);
    chk("shl_sh_out", bus.sh_out, 1'b0);
    step();
    chk("shl_done_pulse", bus.done, 1'b0);
    chk("shl_idle_busy", bus.busy, 1'b0);

    // SAR sign-extends
    do_load(16'h8000);
    run_shift(3'b010, 5'd3, 1'b0, bc);
    chk("sar_q", bus.q, 16'hF000);
    chk("sar_sh_out", bus.sh_out, 1'b0);
    chk("sar_busy_cycles", bc, 2);
    step();

    // ROR by 4
    do_load(16'h1234);
    run_shift(3'b100, 5'd4, 1'b0, bc);
    chk("ror_q", bus.q, 16'h4123);
    chk("ror_sh_out", bus.sh_out, 1'b0);
    chk("ror_done", bus.done, 1'b1);
    step();

    // amt=0: straight to done, q unchanged
    run_shift(3'b000, 5'd0, 1'b1, bc);
    chk("amt0_busy_cycles", bc, 0);
    chk("amt0_done", bus.done, 1'b1);
    chk("amt0_q", bus.q, 16'h4123);
    step();
    chk("amt0_done_pulse", bus.done, 1'b0);

    // SHR by 2 with sh_in=1
    do_load(16'h00F1);
    run_shift(3'b001, 5'd2, 1'b1, bc);
    chk("shr_q", bus.q, 16'hC03C);
    chk("shr_sh_out", bus.sh_out, 1'b0);
    step();

    // ROL by 20 saturates to a full rotation
    do_load(16'h1234);
    run_shift(3'b011, 5'd20, 1'b0, bc);
    chk("rol_sat_q", bus.q, 16'h1234);
    chk("rol_sat_busy_cycles", bc, 15);
    chk("rol_sat_done", bus.done, 1'b1);
    step();

    // Single-step ROR
    do_load(16'h0001);
    run_shift(3'b100, 5'd1, 1'b0, bc);
    chk("ror1_q", bus.q, 16'h8000);
    chk("ror1_sh_out", bus.sh_out, 1'b1);
    chk("ror1_busy_cycles", bc, 0);
    chk("ror1_done", bus.done, 1'b1);
    step();

    // NOP mode: data and sh_out hold, handshake still runs
    run_shift(3'b101, 5'd3, 1'b1, bc);
    chk("nop_q", bus.q, 16'h8000);
    chk("nop_sh_out", bus.sh_out, 1'b1);
    chk("nop_busy_cycles", bc, 2);
    chk("nop_done", bus.done, 1'b1);
    step();

    // start/mode/amt changes during SHIFT are ignored
    do_load(16'h00FF);
    bus.start = 1'b1; bus.mode = 3'b000; bus.amt = 5'd5; bus.sh_in = 1'b0;
    step();
    bus.mode = 3'b100; bus.amt = 5'd1;
    bc = 0;
    for (int i = 0; i < 40 && bus.busy; i++) begin
      bc++;
      step();
    end
    bus.start = 1'b0;
    chk("ign_busy_cycles", bc, 4);
    chk("ign_q", bus.q, 16'h1FE0);
    chk("ign_done", bus.done, 1'b1);
    step();
    chk("ign_idle_busy", bus.busy, 1'b0);

    // Reset mid-shift aborts with no done pulse
    do_load(16'h1234);
    bus.start = 1'b1; bus.mode = 3'b000; bus.amt = 5'd8;
    step();
    bus.start = 1'b0;
    step();
    chk("abort_busy_before", bus.busy, 1'b1);
    rst_b = 1'b0;
    step();
    chk("abort_q", bus.q, 16'h0000);
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    rst_b = 1'b1;
    step();
    chk("abort_no_done", bus.done, 1'b0);
    do_load(16'h000F);
    run_shift(3'b000, 5'd1, 1'b0, bc);
    chk("fresh_q", bus.q, 16'h001E);
    chk("fresh_done", bus.done, 1'b1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
